// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access + writeback stage sitting directly after EX. Accepts one
//   instruction per IDLE cycle. Loads and stores run a req/ack transaction on
//   the data-memory port, and the stage stalls upstream while it is in flight.
//   ALU-style (WB-class) ops write the register file one cycle later with no
//   stall. Every other opcode is retired without a write.
//
//   Optional feature (macro MEM_TIMEOUT_EN):
//     A memory transaction that sees no dm_ack for TIMEOUT WAIT cycles is
//     aborted and mem_err is set (sticky until reset). An aborted load does not
//     write back. Without the macro, WAIT is held until dm_ack and mem_err is
//     tied 0.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   ex_valid   in   EX holds a valid instruction this cycle
//   op_ex      in   opcode of that instruction
//   rd_ex      in   destination register
//   ans_ex     in   EX result / memory address
//   DM_data    in   store data
//   stall      out  upstream must hold (high for the whole WAIT state)
//   dm_req     out  memory request, held until ack
//   dm_we      out  1 = store, 0 = load
//   dm_addr    out  memory address (ans_ex truncated to AW bits)
//   dm_wdata   out  store data
//   dm_rdata   in   load data, sampled in the ack cycle
//   dm_ack     in   one-cycle completion strobe
//   wb_we      out  register-file write strobe (one cycle)
//   wb_rd      out  register-file write index
//   wb_data    out  register-file write data
//   mem_err    out  sticky timeout error
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DW      = 16,
  parameter int AW      = 10,
  parameter int RW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic [5:0]    op_ex,
  input  logic [RW-1:0] rd_ex,
  input  logic [DW-1:0] ans_ex,
  input  logic [DW-1:0] DM_data,
  output logic          stall,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  input  logic          dm_ack,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          mem_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [5:0] OP_LD = 6'b010000;
  localparam logic [5:0] OP_ST = 6'b010001;

  logic [0:0]    r_state;
  logic [RW-1:0] r_rd;        // destination of the in-flight load
  logic          w_is_ld;
  logic          w_is_st;
  logic          w_is_mem;
  logic          w_is_wb;
  logic          w_timeout;

  // Opcode decode
  assign w_is_ld  = (op_ex == OP_LD);
  assign w_is_st  = (op_ex == OP_ST);
  assign w_is_mem = w_is_ld | w_is_st;
  assign w_is_wb  = (op_ex[5:4] == 2'b00) ||
                    (op_ex == 6'b010110) ||
                    ((op_ex >= 6'b011001) && (op_ex <= 6'b011011));

  // stall is still high in the ack cycle; the next instruction is taken on
  // the first IDLE cycle after it.
  assign stall = (r_state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_mem_err;

  // Abort on the WAIT edge that would bring the count to TIMEOUT. An ack in
  // the same cycle takes priority and completes normally.
  assign w_timeout = (r_state == S_WAIT) && !dm_ack &&
                     (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (!dm_ack) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // NOTE: every register below is updated with non-blocking assignments so
  // all of them sample the pre-edge values, which matches real flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rd     <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      // wb_we is a pulse; wb_rd/wb_data keep their last value.
      wb_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (w_is_mem) begin
              r_state  <= S_WAIT;
              dm_req   <= 1'b1;
              dm_we    <= w_is_st;
              dm_addr  <= ans_ex[AW-1:0];   // upper address bits are dropped
              dm_wdata <= DM_data;
              r_rd     <= rd_ex;
            end else if (w_is_wb) begin
              wb_we   <= 1'b1;
              wb_rd   <= rd_ex;
              wb_data <= ans_ex;
            end
          end
        end
        S_WAIT: begin
          if (dm_ack) begin
            r_state <= S_IDLE;
            dm_req  <= 1'b0;
            if (!dm_we) begin
              wb_we   <= 1'b1;
              wb_rd   <= r_rd;
              wb_data <= dm_rdata;
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            dm_req  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
